spe_accumulator: RTL and testbench

- Summing PE stage directly downstream of the partial-sum PEs. It collects FILTER_SIZE signed partial sums per output neuron, one from each PPE row source.
- When a neuron's set is complete, it adds the total to that neuron's membrane potential, compares against THRESHOLD, and emits one spike record.
- Membrane potentials persist across the two timesteps of an image and are cleared after the second.
- Clocked, single-cycle valid/ready handshakes on both sides.

---
 rtl/snn_pkg.sv | 38 +++
 rtl/spe_neuron_fire.sv | 34 +++
 rtl/spe_accumulator.sv | 203 ++++++++++++++++++++
 tb/tb_spe_accumulator.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_pkg.sv
// Shared constants and types for the spiking summing-PE stage.
//   FILTER_SIZE  partial sums per neuron (one per PPE row source)
//   NUM_OUTPUTS  neuron entries held by the accumulator
//   PSUM_WIDTH   signed partial-sum width (SUM_WIDTH + 1)
//   VMEM_WIDTH   signed membrane / accumulator width
//   THRESHOLD    spike threshold (positive)
package snn_pkg;

  localparam int unsigned FILTER_SIZE = 5;
  localparam int unsigned NUM_OUTPUTS = 21;
  localparam int unsigned SUM_WIDTH   = 13;
  localparam int unsigned PSUM_WIDTH  = SUM_WIDTH + 1;
  localparam int unsigned VMEM_WIDTH  = 16;
  localparam int          THRESHOLD   = 64;

  localparam int unsigned SRC_WIDTH = 4;
  localparam int unsigned IDX_WIDTH = 5;
  localparam int unsigned TS_WIDTH  = 2;
  localparam int unsigned ERR_WIDTH = 3;

  // Sticky error flag bit positions.
  localparam int unsigned ErrDupSrc     = 0;
  localparam int unsigned ErrRange      = 1;
  localparam int unsigned ErrIncomplete = 2;

  typedef logic signed [PSUM_WIDTH-1:0] psum_t;
  typedef logic signed [VMEM_WIDTH-1:0] vmem_t;
  typedef logic [FILTER_SIZE-1:0]       mask_t;

  typedef enum logic [2:0] {
    StIdle,
    StAcc,
    StFire,
    StEmit,
    StClr
  } spe_state_t;

endpackage

// File: rtl/spe_neuron_fire.sv
// Combinational fire step for one neuron.
//   vmem_i   current membrane potential
//   acc_i    completed sum of this neuron's partial sums
//   spike_o  1 when the saturated potential reaches THRESHOLD
//   vmem_o   new potential (reset by subtraction on a spike)
module spe_neuron_fire
  import snn_pkg::*;
(
  input  vmem_t vmem_i,
  input  vmem_t acc_i,
  output logic  spike_o,
  output vmem_t vmem_o
);

  localparam vmem_t VmemMax = {1'b0, {(VMEM_WIDTH-1){1'b1}}};
  localparam vmem_t VmemMin = {1'b1, {(VMEM_WIDTH-1){1'b0}}};
  localparam vmem_t Thresh  = vmem_t'(THRESHOLD);

  logic [VMEM_WIDTH:0] sum_wide;
  vmem_t               v_sat;

  always_comb begin
    sum_wide = {vmem_i[VMEM_WIDTH-1], vmem_i} + {acc_i[VMEM_WIDTH-1], acc_i};
    // Top two bits disagree only when the true sum left the VMEM range.
    if (sum_wide[VMEM_WIDTH] != sum_wide[VMEM_WIDTH-1]) begin
      v_sat = sum_wide[VMEM_WIDTH] ? VmemMin : VmemMax;
    end else begin
      v_sat = sum_wide[VMEM_WIDTH-1:0];
    end
    spike_o = (v_sat >= Thresh);
    vmem_o  = spike_o ? (v_sat - Thresh) : v_sat;
  end

endmodule

// File: rtl/spe_accumulator.sv
// Summing PE: gathers FILTER_SIZE partial sums per output neuron, folds the
// total into the neuron's membrane potential and emits one spike record.
//   clk, rst_n               clock, async active-low reset
//   in_valid/in_ready        partial-sum packet handshake (in_src, in_idx, in_psum)
//   ts_done/ts_done_ack      end-of-timestep request and its one-cycle acknowledge
//   out_valid/out_ready      spike record handshake (out_idx, out_spike, out_ts)
//   err_flags                sticky: [0] dup source, [1] out of range, [2] incomplete
module spe_accumulator
  import snn_pkg::*;
(
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [SRC_WIDTH-1:0]  in_src,
  input  logic [IDX_WIDTH-1:0]  in_idx,
  input  logic signed [PSUM_WIDTH-1:0] in_psum,
  input  logic                  ts_done,
  output logic                  ts_done_ack,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [IDX_WIDTH-1:0]  out_idx,
  output logic                  out_spike,
  output logic [TS_WIDTH-1:0]   out_ts,
  output logic [ERR_WIDTH-1:0]  err_flags
);

  localparam logic [IDX_WIDTH-1:0] IdxLimit = IDX_WIDTH'(NUM_OUTPUTS);
  localparam logic [SRC_WIDTH-1:0] SrcLimit = SRC_WIDTH'(FILTER_SIZE);

  spe_state_t state_q, state_d;
  logic [SRC_WIDTH-1:0] src_q, src_d;
  logic [IDX_WIDTH-1:0] idx_q, idx_d;
  psum_t                psum_q, psum_d;
  vmem_t                acc_q  [NUM_OUTPUTS];
  vmem_t                acc_d  [NUM_OUTPUTS];
  mask_t                mask_q [NUM_OUTPUTS];
  mask_t                mask_d [NUM_OUTPUTS];
  vmem_t                vmem_q [NUM_OUTPUTS];
  vmem_t                vmem_d [NUM_OUTPUTS];
  logic [TS_WIDTH-1:0]  ts_q, ts_d;
  logic [ERR_WIDTH-1:0] err_q, err_d;
  logic                 ready_q, ready_d;
  logic                 ack_q, ack_d;
  logic                 out_valid_q, out_valid_d;
  logic [IDX_WIDTH-1:0] out_idx_q, out_idx_d;
  logic                 out_spike_q, out_spike_d;
  logic [TS_WIDTH-1:0]  out_ts_q, out_ts_d;

  logic                 in_range;
  logic [IDX_WIDTH-1:0] idx_safe;
  logic                 any_pending;
  logic                 fire_spike;
  vmem_t                fire_vmem;

  assign in_range = (idx_q < IdxLimit) && (src_q < SrcLimit);
  // Keeps array reads in bounds while a bad packet sits in the latch.
  assign idx_safe = (idx_q < IdxLimit) ? idx_q : '0;

  spe_neuron_fire u_fire (
    .vmem_i  (vmem_q[idx_safe]),
    .acc_i   (acc_q[idx_safe]),
    .spike_o (fire_spike),
    .vmem_o  (fire_vmem)
  );

  always_comb begin
    any_pending = 1'b0;
    for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
      any_pending = any_pending | (|mask_q[i]);
    end
  end

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    idx_d       = idx_q;
    psum_d      = psum_q;
    acc_d       = acc_q;
    mask_d      = mask_q;
    vmem_d      = vmem_q;
    ts_d        = ts_q;
    err_d       = err_q;
    ack_d       = 1'b0;
    out_valid_d = out_valid_q;
    out_idx_d   = out_idx_q;
    out_spike_d = out_spike_q;
    out_ts_d    = out_ts_q;

    unique case (state_q)
      StIdle: begin
        if (ts_done) begin
          state_d = StClr;
          ack_d   = 1'b1;
        end else if (in_valid && in_ready) begin
          src_d   = in_src;
          idx_d   = in_idx;
          psum_d  = in_psum;
          state_d = StAcc;
        end
      end
      StAcc: begin
        state_d = StIdle;
        if (!in_range) begin
          err_d[ErrRange] = 1'b1;
        end else if (mask_q[idx_q][src_q[2:0]]) begin
          err_d[ErrDupSrc] = 1'b1;
        end else begin
          acc_d[idx_q]              = acc_q[idx_q] + vmem_t'(psum_q);
          mask_d[idx_q][src_q[2:0]] = 1'b1;
          if (mask_d[idx_q] == '1) begin
            state_d = StFire;
          end
        end
      end
      StFire: begin
        vmem_d[idx_q] = fire_vmem;
        acc_d[idx_q]  = '0;
        mask_d[idx_q] = '0;
        out_valid_d   = 1'b1;
        out_idx_d     = idx_q;
        out_spike_d   = fire_spike;
        out_ts_d      = ts_q;
        state_d       = StEmit;
      end
      StEmit: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      StClr: begin
        if (any_pending) begin
          err_d[ErrIncomplete] = 1'b1;
        end
        for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
          acc_d[i]  = '0;
          mask_d[i] = '0;
        end
        if (ts_q == TS_WIDTH'(1)) begin
          ts_d = TS_WIDTH'(2);
        end else begin
          ts_d = TS_WIDTH'(1);
          for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
            vmem_d[i] = '0;
          end
        end
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    ready_d = (state_d == StIdle);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      src_q       <= '0;
      idx_q       <= '0;
      psum_q      <= '0;
      for (int unsigned i = 0; i < NUM_OUTPUTS; i++) begin
        acc_q[i]  <= '0;
        mask_q[i] <= '0;
        vmem_q[i] <= '0;
      end
      ts_q        <= TS_WIDTH'(1);
      err_q       <= '0;
      ready_q     <= 1'b0;
      ack_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_idx_q   <= '0;
      out_spike_q <= 1'b0;
      out_ts_q    <= TS_WIDTH'(1);
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      idx_q       <= idx_d;
      psum_q      <= psum_d;
      acc_q       <= acc_d;
      mask_q      <= mask_d;
      vmem_q      <= vmem_d;
      ts_q        <= ts_d;
      err_q       <= err_d;
      ready_q     <= ready_d;
      ack_q       <= ack_d;
      out_valid_q <= out_valid_d;
      out_idx_q   <= out_idx_d;
      out_spike_q <= out_spike_d;
      out_ts_q    <= out_ts_d;
    end
  end

  // ts_done blocks new packets in the same cycle so it wins over in_valid.
  assign in_ready    = ready_q & ~ts_done;
  assign ts_done_ack = ack_q;
  assign out_valid   = out_valid_q;
  assign out_idx     = out_idx_q;
  assign out_spike   = out_spike_q;
  assign out_ts      = out_ts_q;
  assign err_flags   = err_q;

endmodule

// File: tb/tb_spe_accumulator.sv
module tb_spe_accumulator;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_src;
  logic [4:0]  in_idx;
  logic signed [13:0] in_psum;
  logic        ts_done;
  logic        ts_done_ack;
  logic        out_valid;
  logic        out_ready;
  logic [4:0]  out_idx;
  logic        out_spike;
  logic [1:0]  out_ts;
  logic [2:0]  err_flags;

  int n_pass  = 0;
  int n_total = 0;

  // Reference model state: plain integers per neuron.
  int m_acc  [21];
  int m_mask [21];
  int m_vmem [21];
  int m_ts;
  logic [2:0] m_err;

  spe_accumulator dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_src      (in_src),
    .in_idx      (in_idx),
    .in_psum     (in_psum),
    .ts_done     (ts_done),
    .ts_done_ack (ts_done_ack),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_idx     (out_idx),
    .out_spike   (out_spike),
    .out_ts      (out_ts),
    .err_flags   (err_flags)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 21; i++) begin
      m_acc[i] = 0; m_mask[i] = 0; m_vmem[i] = 0;
    end
    m_ts  = 1;
    m_err = '0;
  endtask

  function automatic int wrap16(input int x);
    logic signed [15:0] t;
    t = x[15:0];
    return int'(t);
  endfunction

  // Applies one packet to the model; reports whether a record should appear.
  task automatic model_packet(input int src, input int idx, input int psum,
                              output bit fire, output bit spike);
    int v;
    fire = 0; spike = 0;
    if (idx >= 21 || src >= 5) begin
      m_err[1] = 1'b1;
    end else if (m_mask[idx][src]) begin
      m_err[0] = 1'b1;
    end else begin
      m_acc[idx]  = wrap16(m_acc[idx] + psum);
      m_mask[idx] = m_mask[idx] | (1 << src);
      if (m_mask[idx] == 31) begin
        fire = 1;
        v = m_vmem[idx] + m_acc[idx];
        if (v > 32767) v = 32767;
        if (v < -32768) v = -32768;
        spike = (v >= 64);
        m_vmem[idx] = spike ? v - 64 : v;
        m_acc[idx]  = 0;
        m_mask[idx] = 0;
      end
    end
  endtask

  task automatic send(input int src, input int idx, input int psum, input bit consume);
    bit fire, spike;
    int waited = 0;
    int ts_exp;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    chk("in_ready_wait", in_ready, 1);
    in_valid = 1'b1;
    in_src   = 4'(src);
    in_idx   = 5'(idx);
    in_psum  = 14'(psum);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    ts_exp = m_ts;
    model_packet(src, idx, psum, fire, spike);
    chk("busy_in_acc", in_ready, 0);
    chk("ov_lat1", out_valid, 0);
    tick();
    chk("err_flags", err_flags, m_err);
    if (fire) chk("ov_lat2", out_valid, 0);
    else begin
      chk("ready_back", in_ready, 1);
      chk("no_record", out_valid, 0);
    end
    tick();
    if (fire) begin
      chk("ov_lat3", out_valid, 1);
      chk("out_idx", out_idx, idx);
      chk("out_spike", out_spike, spike);
      chk("out_ts", out_ts, ts_exp);
      if (consume) begin
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("ov_drop", out_valid, 0);
        chk("ready_after_emit", in_ready, 1);
      end
    end else begin
      chk("no_record2", out_valid, 0);
    end
  endtask

  task automatic do_ts_done();
    int waited = 0;
    ts_done = 1'b1;
    #0;
    chk("ts_done_blocks", in_ready, 0);
    tick();
    while (!ts_done_ack && waited < 10) begin
      tick();
      waited++;
    end
    chk("ack_seen", ts_done_ack, 1);
    ts_done = 1'b0;
    for (int i = 0; i < 21; i++) begin
      if (m_mask[i] != 0) m_err[2] = 1'b1;
      m_acc[i]  = 0;
      m_mask[i] = 0;
      if (m_ts == 2) m_vmem[i] = 0;
    end
    m_ts = (m_ts == 1) ? 2 : 1;
    tick();
    chk("ack_pulse", ts_done_ack, 0);
    chk("err_after_clr", err_flags, m_err);
    chk("ready_after_clr", in_ready, 1);
  endtask

  task automatic chk_reset_outputs();
    chk("rst_in_ready", in_ready, 0);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_idx", out_idx, 0);
    chk("rst_out_spike", out_spike, 0);
    chk("rst_out_ts", out_ts, 1);
    chk("rst_ack", ts_done_ack, 0);
    chk("rst_err", err_flags, 0);
  endtask

  initial begin
    int src_r, idx_r, psum_r;
    bit stall_spike;
    rst_n = 1'b0; in_valid = 1'b0; in_src = '0; in_idx = '0; in_psum = '0;
    ts_done = 1'b0; out_ready = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs();
    rst_n = 1'b1;
    tick();
    tick();
    chk("idle_ready", in_ready, 1);

    // Neuron 3: 70 total -> spike, residual 6.
    send(0, 3, 10, 1);
    send(1, 3, 20, 1);
    send(2, 3, 5, 1);
    send(3, 3, 15, 1);
    send(4, 3, 20, 1);
    chk("vmem3_residual", dut.vmem_q[3], 6);

    // Neuron 0 out of order, then carried across the timestep boundary.
    send(4, 0, 1, 1);
    send(2, 0, 1, 1);
    send(0, 0, 1, 1);
    send(3, 0, 1, 1);
    send(1, 0, 1, 1);
    do_ts_done();
    for (int s = 0; s < 5; s++) send(s, 0, 12, 1);
    chk("vmem0_residual", dut.vmem_q[0], 1);

    // Duplicate source on neuron 7.
    send(2, 7, 3, 1);
    send(2, 7, 3, 1);
    chk("dup_err", err_flags[0], 1);
    send(0, 7, 3, 1);
    send(1, 7, 3, 1);
    send(3, 7, 3, 1);
    send(4, 7, 3, 1);

    // Out-of-range index and source.
    send(0, 21, 5, 1);
    send(5, 0, 5, 1);
    chk("range_err", err_flags[1], 1);

    // Incomplete neuron at ts_done, then vmem clearing on the second.
    do_ts_done();
    send(0, 5, 1, 1);
    send(1, 5, 1, 1);
    send(2, 5, 1, 1);
    do_ts_done();
    chk("incomplete_err", err_flags[2], 1);
    for (int s = 0; s < 5; s++) send(s, 9, 12, 1);
    do_ts_done();
    for (int s = 0; s < 5; s++) send(s, 9, 1, 1);
    for (int s = 0; s < 5; s++) send(s, 5, 1, 1);

    // Randomized traffic on a few neurons so sets complete often.
    for (int n = 0; n < 80; n++) begin
      if ($urandom_range(0, 19) == 0) begin
        do_ts_done();
      end else begin
        idx_r  = ($urandom_range(0, 15) == 0) ? 21 + int'($urandom_range(0, 2))
                                              : int'($urandom_range(0, 3));
        src_r  = ($urandom_range(0, 15) == 0) ? 5 + int'($urandom_range(0, 2))
                                              : int'($urandom_range(0, 4));
        psum_r = int'($urandom_range(0, 600)) - 200;
        send(src_r, idx_r, psum_r, 1);
      end
    end

    // Saturation: start from a cleared timestep 1.
    if (m_ts == 1) do_ts_done();
    do_ts_done();
    for (int r = 0; r < 2; r++) for (int s = 0; s < 5; s++) send(s, 11, 6000, 1);
    for (int r = 0; r < 2; r++) for (int s = 0; s < 5; s++) send(s, 12, -6000, 1);
    for (int s = 0; s < 5; s++) send(s, 12, 0, 1);

    // Back-pressure on a pending record, then reset while it is held.
    for (int s = 0; s < 4; s++) send(s, 13, 20, 1);
    stall_spike = 1'b1;
    send(4, 13, 20, 0);
    in_valid = 1'b1; in_src = 4'd0; in_idx = 5'd14; in_psum = 14'd1;
    for (int c = 0; c < 10; c++) begin
      chk("stall_ready", in_ready, 0);
      chk("stall_valid", out_valid, 1);
      chk("stall_idx", out_idx, 13);
      chk("stall_spike", out_spike, stall_spike);
      tick();
    end
    rst_n = 1'b0;
    #1;
    in_valid = 1'b0;
    chk_reset_outputs();
    model_reset();
    tick();
    rst_n = 1'b1;
    tick();
    tick();
    chk("post_reset_ready", in_ready, 1);
    chk("post_reset_vmem13", dut.vmem_q[13], 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
